// File: rtl/pwm_audio_pkg.sv
// Shared types and helpers for the PWM audio players.
// Samples are handled MSB-aligned in MAX_SAMPLE_W bits, so one helper covers every sample width.
package pwm_audio_pkg;

  localparam int MAX_SAMPLE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_STARVE = 2'd2
  } play_state_e;

  // Midscale (2^(W-1)) in MSB-aligned form for any sample width up to MAX_SAMPLE_W.
  localparam logic [MAX_SAMPLE_W-1:0] MIDSCALE_MSB = {1'b1, {(MAX_SAMPLE_W-1){1'b0}}};

  // Expects an MSB-aligned sample. Signed input becomes offset binary by flipping its MSB.
  function automatic logic [MAX_SAMPLE_W-1:0] to_duty(input logic [MAX_SAMPLE_W-1:0] sample,
                                                      input logic                    signed_in);
    logic [MAX_SAMPLE_W-1:0] d;
    d = sample;
    if (signed_in) d[MAX_SAMPLE_W-1] = ~sample[MAX_SAMPLE_W-1];
    return d;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM period timebase: a prescaler feeding a SAMPLE_W-bit period counter.
// period_end marks the final clock of each 2^SAMPLE_W * PRESCALE period.
module pwm_timebase #(
  parameter int SAMPLE_W = 8,
  parameter int PRESCALE = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clr,
  input  logic                run,
  output logic [SAMPLE_W-1:0] count,
  output logic                period_end
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             pre_wrap;

  assign pre_wrap   = (pre_cnt == PRE_LAST);
  assign period_end = pre_wrap && (count == '1);

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      pre_cnt <= '0;
      count   <= '0;
    end else if (run) begin
      if (pre_wrap) begin
        pre_cnt <= '0;
        count   <= count + SAMPLE_W'(1);
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_stream_player.sv
// Double-buffered PWM sample player: packed words in over valid/ready, one sample per PWM period.
// Underruns play midscale until the next word arrives at a period boundary.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | counters held at 0, pwm_o low, waiting for aud_en && pend_full
// ST_PLAY   | playing active[idx]; reloads from pending at word end
// ST_STARVE | no word available, midscale duty until pending fills
module pwm_stream_player
  import pwm_audio_pkg::*;
#(
  parameter int SAMPLE_W         = 8,
  parameter int SAMPLES_PER_WORD = 4,
  parameter int DATA_W           = SAMPLE_W * SAMPLES_PER_WORD,
  parameter int PRESCALE         = 1,
  parameter int SIGNED_IN        = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              aud_en,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              pwm_o,
  output logic              busy_o,
  output logic              underrun_o
);

  localparam int IDX_W  = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;
  localparam int ALIGN  = MAX_SAMPLE_W - SAMPLE_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLES_PER_WORD - 1);

  play_state_e             state;
  logic [DATA_W-1:0]       pend_word;
  logic [DATA_W-1:0]       active_word;
  logic                    pend_full;
  logic [IDX_W-1:0]        idx;
  logic [SAMPLE_W-1:0]     count;
  logic                    period_end;
  logic [SAMPLE_W-1:0]     sample;
  logic [MAX_SAMPLE_W-1:0] duty_al;
  logic [MAX_SAMPLE_W-1:0] cmp_duty;
  logic [MAX_SAMPLE_W-1:0] count_al;
  logic                    accept;
  logic                    tb_clr;

  assign ready_o = !pend_full;
  assign busy_o  = (state != ST_IDLE);
  assign accept  = valid_i && ready_o;
  assign tb_clr  = !aud_en || (state == ST_IDLE);

  pwm_timebase #(
    .SAMPLE_W (SAMPLE_W),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (tb_clr),
    .run        (!tb_clr),
    .count      (count),
    .period_end (period_end)
  );

  always_comb begin
    sample = '0;
    for (int k = 0; k < SAMPLES_PER_WORD; k++) begin
      if (idx == IDX_W'(k)) sample = active_word[DATA_W-1-k*SAMPLE_W -: SAMPLE_W];
    end
  end

  // Compare is done MSB-aligned; the zero low bits on both sides leave the ordering unchanged.
  assign duty_al  = to_duty(MAX_SAMPLE_W'(sample) << ALIGN, SIGNED_IN != 0);
  assign cmp_duty = (state == ST_STARVE) ? MIDSCALE_MSB : duty_al;
  assign count_al = MAX_SAMPLE_W'(count) << ALIGN;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      pend_word   <= '0;
      active_word <= '0;
      pend_full   <= 1'b0;
      idx         <= '0;
      pwm_o       <= 1'b0;
      underrun_o  <= 1'b0;
    end else begin
      underrun_o <= 1'b0;
      if (accept) begin
        pend_word <= data_i;
        pend_full <= 1'b1;
      end
      if (!aud_en) begin
        state <= ST_IDLE;
        idx   <= '0;
        pwm_o <= 1'b0;
      end else begin
        pwm_o <= (state != ST_IDLE) && (count_al < cmp_duty);
        case (state)
          ST_IDLE: begin
            if (pend_full) begin
              active_word <= pend_word;
              idx         <= '0;
              pend_full   <= 1'b0;
              state       <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (period_end) begin
              if (idx != IDX_LAST) begin
                idx <= idx + IDX_W'(1);
              end else if (pend_full) begin
                active_word <= pend_word;
                idx         <= '0;
                pend_full   <= 1'b0;
              end else begin
                state      <= ST_STARVE;
                underrun_o <= 1'b1;
              end
            end
          end
          ST_STARVE: begin
            if (period_end && pend_full) begin
              active_word <= pend_word;
              idx         <= '0;
              pend_full   <= 1'b0;
              state       <= ST_PLAY;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_stream_player.sv
// Directed bench for pwm_stream_player: an unsigned PRESCALE=1 instance and a signed PRESCALE=2 instance.
module tb_pwm_stream_player;

  logic        clk;
  logic        rstn;
  logic        u_aud_en, u_valid, u_ready, u_pwm, u_busy, u_ur;
  logic [31:0] u_data;
  logic        s_aud_en, s_valid, s_ready, s_pwm, s_busy, s_ur;
  logic [31:0] s_data;

  int tests = 0;
  int fails = 0;

  pwm_stream_player #(
    .SAMPLE_W(8), .SAMPLES_PER_WORD(4), .PRESCALE(1), .SIGNED_IN(0)
  ) dut_u (
    .clk(clk), .rstn(rstn), .aud_en(u_aud_en), .data_i(u_data), .valid_i(u_valid),
    .ready_o(u_ready), .pwm_o(u_pwm), .busy_o(u_busy), .underrun_o(u_ur)
  );

  pwm_stream_player #(
    .SAMPLE_W(8), .SAMPLES_PER_WORD(4), .PRESCALE(2), .SIGNED_IN(1)
  ) dut_s (
    .clk(clk), .rstn(rstn), .aud_en(s_aud_en), .data_i(s_data), .valid_i(s_valid),
    .ready_o(s_ready), .pwm_o(s_pwm), .busy_o(s_busy), .underrun_o(s_ur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents one word for exactly one rising edge; returns 1 time unit after that edge.
  task automatic send(input bit sel, input logic [31:0] w);
    if (sel) begin s_data = w; s_valid = 1'b1; end
    else     begin u_data = w; u_valid = 1'b1; end
    @(posedge clk);
    #1;
    if (sel) s_valid = 1'b0;
    else     u_valid = 1'b0;
  endtask

  // Samples n falling edges, checking pwm high count, underrun pulses and busy cycles.
  task automatic win(input bit sel, input int n, input string tag,
                     input int exp_high, input int exp_ur);
    int highs, urs, busys;
    highs = 0; urs = 0; busys = 0;
    repeat (n) begin
      @(negedge clk);
      if (sel) begin highs += int'(s_pwm); urs += int'(s_ur); busys += int'(s_busy); end
      else     begin highs += int'(u_pwm); urs += int'(u_ur); busys += int'(u_busy); end
    end
    check({tag, "_high"}, highs, exp_high);
    check({tag, "_ur"},   urs,   exp_ur);
    check({tag, "_busy"}, busys, n);
  endtask

  initial begin
    rstn = 1'b0;
    u_aud_en = 1'b1; u_valid = 1'b1; u_data = 32'h0080FF01;
    s_aud_en = 1'b1; s_valid = 1'b0; s_data = 32'h0;

    repeat (3) begin
      @(negedge clk);
      check("rst_pwm", u_pwm, 0);
      check("rst_busy", u_busy, 0);
    end
    rstn = 1'b1; u_valid = 1'b0;
    @(negedge clk);
    check("rst_ready", u_ready, 1);
    check("rst_no_accept_busy", u_busy, 0);
    check("rst_ready_s", s_ready, 1);

    // Unsigned word, then underrun
    send(0, 32'h0080FF01);
    check("a_acc_ready", u_ready, 0);
    @(negedge clk);
    check("a_idle_busy", u_busy, 0);
    @(negedge clk);
    check("a_play_busy", u_busy, 1);
    check("a_first_pwm", u_pwm, 0);
    win(0, 256, "a_s0", 0, 0);
    win(0, 256, "a_s1", 128, 0);
    win(0, 256, "a_s2", 255, 0);
    win(0, 256, "a_s3", 1, 1);
    win(0, 256, "starve1", 128, 0);

    // Recovery: new word starts at the next period end
    send(0, 32'h40C02010);
    check("b_acc_ready", u_ready, 0);
    win(0, 255, "starve2", 128, 0);
    win(0, 1, "starve_end", 0, 0);
    check("b_loaded_ready", u_ready, 1);

    // Streaming: next word queued while B plays
    send(0, 32'hFF00C080);
    check("c_acc_ready", u_ready, 0);
    win(0, 256, "b_s0", 64, 0);
    win(0, 256, "b_s1", 192, 0);
    win(0, 256, "b_s2", 32, 0);
    win(0, 256, "b_s3", 16, 0);
    win(0, 256, "c_s0", 255, 0);

    // Enable drop mid-sample 2 with a pending word
    send(0, 32'h10203040);
    check("d_acc_ready", u_ready, 0);
    win(0, 256, "c_s1", 0, 0);
    win(0, 100, "c_s2_part", 100, 0);
    u_aud_en = 1'b0;
    @(posedge clk);
    #1;
    check("drop_pwm", u_pwm, 0);
    check("drop_busy", u_busy, 0);
    check("drop_ready", u_ready, 0);
    @(negedge clk);
    check("drop_pwm_hold", u_pwm, 0);
    u_aud_en = 1'b1;
    @(negedge clk);
    check("reen_busy", u_busy, 1);
    check("reen_pwm", u_pwm, 0);
    check("reen_ready", u_ready, 1);
    win(0, 256, "d_s0", 16, 0);
    win(0, 256, "d_s1", 32, 0);
    u_aud_en = 1'b0;

    // Signed mode, PRESCALE=2: 0x80,0x00,0x7F,0xC0 -> duties 0,128,255,64
    send(1, 32'h80007FC0);
    check("s_acc_ready", s_ready, 0);
    @(negedge clk);
    check("s_idle_busy", s_busy, 0);
    @(negedge clk);
    check("s_play_busy", s_busy, 1);
    win(1, 512, "s_s0", 0, 0);
    win(1, 512, "s_s1", 256, 0);
    win(1, 512, "s_s2", 510, 0);
    win(1, 512, "s_s3", 128, 1);
    win(1, 512, "s_starve", 256, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
